// File: rtl/alu_if.sv
// Operand, opcode and result/flag bundle for the MIPS ALU.
// The datapath side drives operands; the ALU drives results and flags.
interface alu_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  ALUControl;
  logic [31:0] ALUResult;
  logic        zero;
  logic        overflow;
  logic        carry;
  logic [31:0] ALUResult_q;
  logic        zero_q;
  logic        ovf_sticky;

  modport master (
    output SrcA, SrcB, ALUControl,
    input  ALUResult, zero, overflow, carry, ALUResult_q, zero_q, ovf_sticky
  );

  modport slave (
    input  SrcA, SrcB, ALUControl,
    output ALUResult, zero, overflow, carry, ALUResult_q, zero_q, ovf_sticky
  );
endinterface

// File: rtl/alu.sv
// Combinational 32-bit MIPS ALU with a registered result/zero copy and a
// sticky signed-overflow flag for debug and exception logic.
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_SUB  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SLT  = 3'b110,
    OP_SLTU = 3'b111
  } alu_op_e;

  alu_op_e     op;
  logic [31:0] a;
  logic [31:0] b;
  logic [32:0] add_full;
  logic [32:0] sub_full;
  logic        add_ovf;
  logic        sub_ovf;
  logic        slt_bit;
  logic        sltu_bit;
  logic [31:0] result;
  logic        ovf;
  logic        cout;
  logic        is_zero;

  assign op = alu_op_e'(bus.ALUControl);
  assign a  = bus.SrcA;
  assign b  = bus.SrcB;

  // SLT/SLTU reuse the subtractor: signed less-than is sign XOR overflow,
  // unsigned less-than is the absence of a carry out of A + ~B + 1.
  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_full = {1'b0, a} + {1'b0, ~b} + 33'd1;
    add_ovf  = (a[31] == b[31]) && (add_full[31] != a[31]);
    sub_ovf  = (a[31] != b[31]) && (sub_full[31] != a[31]);
    slt_bit  = sub_full[31] ^ sub_ovf;
    sltu_bit = ~sub_full[32];
  end

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    cout   = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD: begin
        result = add_full[31:0];
        ovf    = add_ovf;
        cout   = add_full[32];
      end
      OP_XOR:  result = a ^ b;
      OP_SUB: begin
        result = sub_full[31:0];
        ovf    = sub_ovf;
        cout   = sub_full[32];
      end
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {31'd0, slt_bit};
      OP_SLTU: result = {31'd0, sltu_bit};
      default: result = '0;
    endcase
    is_zero = (result == 32'd0);
  end

  assign bus.ALUResult = result;
  assign bus.zero      = is_zero;
  assign bus.overflow  = ovf;
  assign bus.carry     = cout;

  logic [31:0] result_q;
  logic        zero_q;
  logic        sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      result_q <= result;
      zero_q   <= is_zero;
      if (ovf) sticky <= 1'b1;
    end
  end

  assign bus.ALUResult_q = result_q;
  assign bus.zero_q      = zero_q;
  assign bus.ovf_sticky  = sticky;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: table of vectors fed through a scoreboard
// queue, plus hand-written reset/sticky sequences.
module tb_alu;
  logic clk;
  logic rst_n;
  alu_if bus();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctl;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        c;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];
  vec_t sb[$];
  vec_t exp_v;
  int   checks;
  int   failures;
  logic model_sticky;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    model_sticky = 1'b0;

    vecs[0]  = '{32'h00000001, 32'h00000002, 3'b010, 32'h00000003, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h00000001, 32'h00000002, 3'b100, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h00000005, 32'h00000005, 3'b100, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{32'h00000001, 32'h00000001, 3'b110, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h80000000, 32'h00000001, 3'b110, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b000, 32'hF000F000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b001, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b011, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hF0F0F0F0, 32'hFF00FF00, 3'b101, 32'h000F000F, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{32'h7FFFFFFF, 32'h80000000, 3'b110, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{32'h80000000, 32'h00000001, 3'b100, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{32'h00000000, 32'h00000000, 3'b100, 32'h00000000, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    bus.SrcA = '0;
    bus.SrcB = '0;
    bus.ALUControl = 3'b000;
    #3;
    check("reset_result_q", bus.ALUResult_q, 32'd0);
    check("reset_zero_q", {31'd0, bus.zero_q}, 32'd0);
    check("reset_sticky", {31'd0, bus.ovf_sticky}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.SrcA = vecs[i].a;
      bus.SrcB = vecs[i].b;
      bus.ALUControl = vecs[i].ctl;
      sb.push_back(vecs[i]);
      #1;
      exp_v = sb[0];
      check($sformatf("v%0d_result", i), bus.ALUResult, exp_v.res);
      check($sformatf("v%0d_zero", i), {31'd0, bus.zero}, {31'd0, exp_v.z});
      check($sformatf("v%0d_overflow", i), {31'd0, bus.overflow}, {31'd0, exp_v.o});
      check($sformatf("v%0d_carry", i), {31'd0, bus.carry}, {31'd0, exp_v.c});
      @(posedge clk);
      #1;
      exp_v = sb.pop_front();
      model_sticky = model_sticky | exp_v.o;
      check($sformatf("v%0d_result_q", i), bus.ALUResult_q, exp_v.res);
      check($sformatf("v%0d_zero_q", i), {31'd0, bus.zero_q}, {31'd0, exp_v.z});
      check($sformatf("v%0d_sticky", i), {31'd0, bus.ovf_sticky}, {31'd0, model_sticky});
    end

    // Register capture, then asynchronous reset mid-cycle.
    @(negedge clk);
    bus.SrcA = 32'd1;
    bus.SrcB = 32'd2;
    bus.ALUControl = 3'b010;
    @(posedge clk);
    #1;
    check("seq_add_result_q", bus.ALUResult_q, 32'd3);
    check("seq_add_zero_q", {31'd0, bus.zero_q}, 32'd0);
    check("seq_pre_reset_sticky", {31'd0, bus.ovf_sticky}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_result_q", bus.ALUResult_q, 32'd0);
    check("async_rst_zero_q", {31'd0, bus.zero_q}, 32'd0);
    check("async_rst_sticky", {31'd0, bus.ovf_sticky}, 32'd0);
    check("async_rst_comb_result", bus.ALUResult, 32'd3);

    // Overflow at an edge while reset is held: reset wins.
    @(negedge clk);
    bus.SrcA = 32'h7FFFFFFF;
    bus.SrcB = 32'd1;
    bus.ALUControl = 3'b010;
    #1;
    check("rst_comb_overflow", {31'd0, bus.overflow}, 32'd1);
    @(posedge clk);
    #1;
    check("rst_hold_sticky", {31'd0, bus.ovf_sticky}, 32'd0);
    check("rst_hold_result_q", bus.ALUResult_q, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    bus.SrcA = 32'd1;
    bus.SrcB = 32'd2;
    @(posedge clk);
    #1;
    check("post_rst_result_q", bus.ALUResult_q, 32'd3);
    check("post_rst_sticky", {31'd0, bus.ovf_sticky}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
